// File: rtl/param_arith_pkg.sv
// Shared types and elaboration-time helpers for the pipelined arithmetic datapath.
package param_arith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Position of the carry/borrow flag above the WIDTH-bit sum in a result word.
  function automatic int unsigned result_flag_bit(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  function automatic int unsigned chunk_lsb(input int unsigned k,
                                            input int unsigned chunk);
    return k * chunk;
  endfunction

endpackage

// File: rtl/param_pipe_addsub_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice; also exposes the carry into its MSB
// so the last slice can derive signed overflow.
module rca_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic [CHUNK:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout     = c[CHUNK];
    c_msb_in = c[CHUNK-1];
  end

endmodule

// File: rtl/param_pipe_addsub.sv
// Pipelined WIDTH-bit add/subtract: one ripple chunk per stage, carry registered between
// stages, global valid/ready stall. Define PARAM_ADDSUB_OVF_EN to add the ovf_po output.
module param_pipe_addsub
  import param_arith_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic             valid_pi,
  output logic             ready_po,
  input  op_e              op_pi,
  input  logic [WIDTH-1:0] A_pi,
  input  logic [WIDTH-1:0] B_pi,
  output logic             valid_po,
  input  logic             ready_pi,
  output logic [WIDTH:0]   result_po
`ifdef PARAM_ADDSUB_OVF_EN
  ,
  output logic             ovf_po
`endif
);

  localparam int unsigned CHUNK    = chunk_width(WIDTH, STAGES);
  localparam int unsigned FLAG_BIT = result_flag_bit(WIDTH);

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("param_pipe_addsub: WIDTH must be a multiple of STAGES");
  end

  // Per-stage inputs. x carries the A bits still to be added in its low part and the
  // finished sum chunks in its high part; both x and y rotate down one chunk per stage,
  // so the chunk a stage consumes is always [CHUNK-1:0].
  logic [WIDTH-1:0] x_in  [STAGES];
  logic [WIDTH-1:0] y_in  [STAGES];
  logic             c_in  [STAGES];
  op_e              op_in [STAGES];
  logic             v_in  [STAGES];
  logic             advance;

  assign advance  = ready_pi | ~valid_po;
  assign ready_po = advance;

  // Subtraction is A + ~B + 1: invert B up front, the +1 enters as stage-0 carry-in.
  assign x_in[0]  = A_pi;
  assign y_in[0]  = (op_pi == OP_SUB) ? ~B_pi : B_pi;
  assign c_in[0]  = (op_pi == OP_SUB);
  assign op_in[0] = op_pi;
  assign v_in[0]  = valid_pi;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] s;
    logic             cout;
    logic             c_msb;
    logic [WIDTH-1:0] x_next;

    rca_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a       (x_in[k][CHUNK-1:0]),
      .b       (y_in[k][CHUNK-1:0]),
      .cin     (c_in[k]),
      .sum     (s),
      .cout    (cout),
      .c_msb_in(c_msb)
    );

    assign x_next = (x_in[k] >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] x_q;
      logic [WIDTH-1:0] y_q;
      logic             c_q;
      logic             v_q;
      op_e              op_q;
      logic             unused_c_msb;

      assign unused_c_msb = c_msb;

      // Skew register: partial sum, remaining operand chunks, carry, op and valid.
      always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
          x_q  <= '0;
          y_q  <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
          op_q <= OP_ADD;
        end else if (advance) begin
          x_q  <= x_next;
          y_q  <= (y_in[k] >> CHUNK) | (y_in[k] << (WIDTH - CHUNK));
          c_q  <= cout;
          v_q  <= v_in[k];
          op_q <= op_in[k];
        end
      end

      assign x_in[k+1]  = x_q;
      assign y_in[k+1]  = y_q;
      assign c_in[k+1]  = c_q;
      assign v_in[k+1]  = v_q;
      assign op_in[k+1] = op_q;
    end else begin : g_last
      logic           flag;
      logic [WIDTH:0] res_next;
      logic           unused_last;

      // Carry-out for ADD; for SUB a missing carry means a borrow (A < B).
      assign flag = (op_in[k] == OP_SUB) ? ~cout : cout;

      always_comb begin
        res_next           = {1'b0, x_next};
        res_next[FLAG_BIT] = flag;
      end

      always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
          valid_po  <= 1'b0;
          result_po <= '0;
        end else if (advance) begin
          valid_po  <= v_in[k];
          result_po <= res_next;
        end
      end

`ifdef PARAM_ADDSUB_OVF_EN
      assign unused_last = ^y_in[k];

      // Signed overflow: carry into the MSB disagrees with carry out of it.
      always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
          ovf_po <= 1'b0;
        end else if (advance) begin
          ovf_po <= c_msb ^ cout;
        end
      end
`else
      assign unused_last = ^{c_msb, y_in[k]};
`endif
    end
  end

endmodule
